// File: rtl/camera_frame_gen.sv
// OV7670-style VSYNC/HREF/byte transmitter producing RGB565 test patterns, one byte per CLK.
// Every output is registered. A frame starts on the edge that samples EN. EN is read only at frame boundaries, and there is no backpressure.
module camera_frame_gen #(
  parameter int H_PIXELS     = 176,
  parameter int V_LINES      = 144,
  parameter int H_BLANK      = 16,
  parameter int VSYNC_CYCLES = 8,
  parameter int V_FRONT      = 8,
  parameter int V_BACK       = 8,
  parameter int BAR_W        = 22
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        EN,
  input  logic [1:0]  PATTERN,
  input  logic [15:0] COLOR_IN,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  DATA,
  output logic [7:0]  PIX_X,
  output logic [7:0]  PIX_Y,
  output logic        FRAME_DONE
);

  localparam int LINE_CYC = 2 * H_PIXELS;
  localparam int M1   = (LINE_CYC > H_BLANK) ? LINE_CYC : H_BLANK;
  localparam int M2   = (M1 > VSYNC_CYCLES) ? M1 : VSYNC_CYCLES;
  localparam int M3   = (M2 > V_FRONT) ? M2 : V_FRONT;
  localparam int CMAX = (M3 > V_BACK) ? M3 : V_BACK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {IDLE, VS, VFRONT, LINE, HBLANK, VBACK} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [7:0]      x, x_nxt, y, y_nxt;
  logic [2:0]      bar_idx, bar_idx_nxt;
  logic [BW-1:0]   bar_cnt, bar_cnt_nxt;
  logic [1:0]      pat_q, pat_nxt;
  logic [15:0]     col_q, col_nxt;
  logic            done_nxt;
  logic [15:0]     word_nxt;
  logic [7:0]      byte_nxt;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CW'(1);
    x_nxt       = x;
    y_nxt       = y;
    bar_idx_nxt = bar_idx;
    bar_cnt_nxt = bar_cnt;
    pat_nxt     = pat_q;
    col_nxt     = col_q;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (EN) begin
          state_nxt = VS;
          pat_nxt   = PATTERN;
          col_nxt   = COLOR_IN;
        end
      end
      VS: if (cnt == CW'(VSYNC_CYCLES - 1)) begin
        state_nxt = VFRONT;
        cnt_nxt   = '0;
      end
      VFRONT: if (cnt == CW'(V_FRONT - 1)) begin
        state_nxt = LINE;
        cnt_nxt   = '0;
      end
      LINE: begin
        if (cnt == CW'(LINE_CYC - 1)) begin
          cnt_nxt     = '0;
          x_nxt       = '0;
          bar_idx_nxt = '0;
          bar_cnt_nxt = '0;
          if (y == 8'(V_LINES - 1)) begin
            state_nxt = VBACK;
            y_nxt     = '0;
          end else begin
            state_nxt = HBLANK;
            y_nxt     = y + 8'd1;
          end
        end else if (cnt[0]) begin
          // Odd byte just went out: advance the pixel and the divider-free bar tracker.
          x_nxt = x + 8'd1;
          if (bar_cnt == BW'(BAR_W - 1)) begin
            bar_cnt_nxt = '0;
            if (bar_idx != 3'd7) bar_idx_nxt = bar_idx + 3'd1;
          end else begin
            bar_cnt_nxt = bar_cnt + BW'(1);
          end
        end
      end
      HBLANK: if (cnt == CW'(H_BLANK - 1)) begin
        state_nxt = LINE;
        cnt_nxt   = '0;
      end
      VBACK: if (cnt == CW'(V_BACK - 1)) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
        if (EN) begin
          state_nxt = VS;
          pat_nxt   = PATTERN;
          col_nxt   = COLOR_IN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    word_nxt = 16'h0000;
    case (pat_nxt)
      2'd0:    word_nxt = col_nxt;
      2'd1:    word_nxt = bar_color(bar_idx_nxt);
      2'd2:    word_nxt = {x_nxt[7:3], x_nxt[7:2], x_nxt[7:3]};
      default: word_nxt = (x_nxt[3] ^ y_nxt[3]) ? 16'hFFFF : 16'h0000;
    endcase
    byte_nxt = 8'h00;
    if (state_nxt == LINE) byte_nxt = cnt_nxt[0] ? word_nxt[7:0] : word_nxt[15:8];
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state   <= IDLE;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      bar_idx <= '0;
      bar_cnt <= '0;
      pat_q   <= '0;
      col_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      bar_idx <= bar_idx_nxt;
      bar_cnt <= bar_cnt_nxt;
      pat_q   <= pat_nxt;
      col_q   <= col_nxt;
    end
  end

  // Outputs register the next-state view, so DATA, HREF and PIX_X/PIX_Y stay cycle-aligned.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      DATA       <= 8'h00;
      PIX_X      <= 8'h00;
      PIX_Y      <= 8'h00;
      FRAME_DONE <= 1'b0;
    end else begin
      VSYNC      <= (state_nxt == VS);
      HREF       <= (state_nxt == LINE);
      DATA       <= byte_nxt;
      PIX_X      <= x_nxt;
      PIX_Y      <= y_nxt;
      FRAME_DONE <= done_nxt;
    end
  end

endmodule

// File: tb/tb_camera_frame_gen.sv
// Directed bench: a full-size instance checks the default frame timing, and a 10-line instance checks the patterns, back-to-back frames and reset.
`timescale 1ns/1ps
module tb_camera_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res, en_s, en_f;
  logic [1:0]  pattern;
  logic [15:0] color;

  logic       vs_s, hr_s, fd_s, vs_f, hr_f, fd_f;
  logic [7:0] d_s, px_s, py_s, d_f, px_f, py_f;

  camera_frame_gen #(.V_LINES(10)) u_small (
    .CLK(clk), .RES(res), .EN(en_s), .PATTERN(pattern), .COLOR_IN(color),
    .VSYNC(vs_s), .HREF(hr_s), .DATA(d_s), .PIX_X(px_s), .PIX_Y(py_s), .FRAME_DONE(fd_s)
  );

  camera_frame_gen u_full (
    .CLK(clk), .RES(res), .EN(en_f), .PATTERN(pattern), .COLOR_IN(color),
    .VSYNC(vs_f), .HREF(hr_f), .DATA(d_f), .PIX_X(px_f), .PIX_Y(py_f), .FRAME_DONE(fd_f)
  );

  int tests = 0;
  int fails = 0;
  int dz_err, ix_err;
  logic [15:0] img [0:1][0:9][0:175];

  typedef struct {
    logic [1:0]  pat;
    logic [15:0] col;
    int          x;
    int          y;
    logic [15:0] exp;
    string       name;
  } vec_t;
  localparam int NV = 22;
  vec_t vt [0:NV-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Samples the small instance until FRAME_DONE and stores each pixel word into img[f].
  task automatic cap_frame(input int f, input int chg_y, input logic [1:0] new_pat,
                           input int drop_y, output bit seen);
    int   bidx = 0;
    int   line = -1;
    logic prev = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (fd_s) begin
        seen = 1'b1;
        break;
      end
      if (hr_s) begin
        if (!prev) begin
          bidx = 0;
          line++;
        end
        if (px_s != 8'(bidx / 2) || py_s != 8'(line)) ix_err++;
        if (py_s < 8'd10 && px_s < 8'd176) begin
          if (bidx % 2 == 0) img[f][py_s][px_s][15:8] = d_s;
          else               img[f][py_s][px_s][7:0]  = d_s;
        end
        bidx++;
        if (int'(py_s) == chg_y)  pattern = new_pat;
        if (int'(py_s) == drop_y) en_s = 1'b0;
      end else if (d_s != 8'h00) begin
        dz_err++;
      end
      prev = hr_s;
    end
  endtask

  initial begin
    int  err, t, vs_len, lowrun, first_gap, pulses, hlen, len_bad, gap_bad;
    int  tail, flen, byte_err, dz, got;
    int  cur_pat;
    logic [15:0] cur_col;
    bit  started, seen;
    logic prev_h;

    vt[0]  = '{2'd0, 16'h1234,   0, 0, 16'h1234, "solid_0_0"};
    vt[1]  = '{2'd0, 16'h1234, 175, 9, 16'h1234, "solid_175_9"};
    vt[2]  = '{2'd1, 16'h0000,   0, 0, 16'hFFFF, "bar_x0"};
    vt[3]  = '{2'd1, 16'h0000,  21, 0, 16'hFFFF, "bar_x21"};
    vt[4]  = '{2'd1, 16'h0000,  22, 0, 16'hFFE0, "bar_x22"};
    vt[5]  = '{2'd1, 16'h0000,  43, 0, 16'hFFE0, "bar_x43"};
    vt[6]  = '{2'd1, 16'h0000,  44, 0, 16'h07FF, "bar_x44"};
    vt[7]  = '{2'd1, 16'h0000,  66, 0, 16'h07E0, "bar_x66"};
    vt[8]  = '{2'd1, 16'h0000,  88, 0, 16'hF81F, "bar_x88"};
    vt[9]  = '{2'd1, 16'h0000, 110, 0, 16'hF800, "bar_x110"};
    vt[10] = '{2'd1, 16'h0000, 132, 0, 16'h001F, "bar_x132"};
    vt[11] = '{2'd1, 16'h0000, 153, 0, 16'h001F, "bar_x153"};
    vt[12] = '{2'd1, 16'h0000, 154, 0, 16'h0000, "bar_x154"};
    vt[13] = '{2'd1, 16'h0000, 175, 0, 16'h0000, "bar_x175"};
    vt[14] = '{2'd1, 16'h0000,  22, 5, 16'hFFE0, "bar_x22_y5"};
    vt[15] = '{2'd2, 16'h0000, 175, 0, 16'hAD75, "ramp_x175"};
    vt[16] = '{2'd2, 16'h0000,   8, 0, 16'h0841, "ramp_x8"};
    vt[17] = '{2'd2, 16'h0000,   0, 3, 16'h0000, "ramp_x0"};
    vt[18] = '{2'd3, 16'h0000,   8, 0, 16'hFFFF, "chk_8_0"};
    vt[19] = '{2'd3, 16'h0000,   8, 8, 16'h0000, "chk_8_8"};
    vt[20] = '{2'd3, 16'h0000,   0, 0, 16'h0000, "chk_0_0"};
    vt[21] = '{2'd3, 16'h0000,   0, 8, 16'hFFFF, "chk_0_8"};

    res = 1'b1; en_s = 1'b0; en_f = 1'b0; pattern = 2'd0; color = 16'h0000;
    repeat (3) @(negedge clk);
    res = 1'b0;

    err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({vs_s, hr_s, d_s, px_s, py_s, fd_s, vs_f, hr_f, d_f, px_f, py_f, fd_f} != '0) err++;
    end
    check("idle_outputs_zero", err, 0);

    // Full-size frame: timing plus solid F81F byte order.
    pattern = 2'd0; color = 16'hF81F; en_f = 1'b1;
    started = 0; t = 0; vs_len = 0; lowrun = 0; first_gap = -1; pulses = 0; hlen = 0;
    len_bad = 0; gap_bad = 0; tail = -1; flen = -1; byte_err = 0; dz = 0; prev_h = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (!started) begin
        if (!vs_f) continue;
        started = 1;
        en_f = 1'b0;
      end
      if (fd_f) begin
        flen = t;
        tail = lowrun;
        break;
      end
      if (vs_f) begin
        vs_len++;
        lowrun = 0;
      end
      if (hr_f) begin
        if (!prev_h) begin
          pulses++;
          if (pulses == 1) first_gap = lowrun;
          else if (lowrun != 16) gap_bad++;
          hlen = 0;
        end
        if (d_f != ((hlen % 2 == 0) ? 8'hF8 : 8'h1F)) byte_err++;
        hlen++;
        lowrun = 0;
      end else begin
        if (prev_h && hlen != 352) len_bad++;
        if (d_f != 8'h00) dz++;
        if (!vs_f) lowrun++;
      end
      prev_h = hr_f;
      t++;
    end
    check("vsync_width", vs_len, 8);
    check("vfront_gap", first_gap, 8);
    check("href_pulses", pulses, 144);
    check("href_len_bad", len_bad, 0);
    check("hblank_gap_bad", gap_bad, 0);
    check("vback_tail", tail, 8);
    check("frame_len", flen, 53000);
    check("solid_byte_err", byte_err, 0);
    check("full_data_zero_err", dz, 0);
    check("full_vsync_in_done", vs_f, 1'b0);
    err = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({vs_f, hr_f, d_f, px_f, py_f, fd_f} != '0) err++;
    end
    check("full_idle_after", err, 0);

    // Pattern table on the 10-line instance.
    cur_pat = -1; cur_col = 16'h0000;
    for (int i = 0; i < NV; i++) begin
      if (cur_pat != int'(vt[i].pat) || cur_col != vt[i].col) begin
        cur_pat = int'(vt[i].pat);
        cur_col = vt[i].col;
        pattern = vt[i].pat;
        color   = vt[i].col;
        dz_err = 0; ix_err = 0;
        en_s = 1'b1;
        cap_frame(0, -1, 2'd0, 0, seen);
        check("frame_done_seen", seen, 1'b1);
        check("data_zero_err", dz_err, 0);
        check("pix_index_err", ix_err, 0);
      end
      check(vt[i].name, img[0][vt[i].y][vt[i].x], vt[i].exp);
    end

    // Back-to-back: pattern change in frame 1 takes effect only in frame 2; EN drop in frame 2.
    @(negedge clk);
    pattern = 2'd1; color = 16'h0000; en_s = 1'b1;
    dz_err = 0; ix_err = 0;
    cap_frame(0, 5, 2'd3, -1, seen);
    check("b2b_f1_done", seen, 1'b1);
    check("b2b_vsync_in_done", vs_s, 1'b1);
    check("b2b_f1_bar_y5", img[0][5][22], 16'hFFE0);
    check("b2b_f1_bar_y9", img[0][9][8], 16'hFFFF);
    cap_frame(1, -1, 2'd0, 2, seen);
    check("b2b_f2_done", seen, 1'b1);
    check("b2b_f2_vsync_done", vs_s, 1'b0);
    check("b2b_f2_chk_8_0", img[1][0][8], 16'hFFFF);
    check("b2b_f2_chk_8_8", img[1][8][8], 16'h0000);
    check("b2b_f2_chk_8_9", img[1][9][8], 16'h0000);
    check("b2b_data_zero_err", dz_err, 0);
    check("b2b_pix_index_err", ix_err, 0);
    err = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({vs_s, hr_s, d_s, px_s, py_s, fd_s} != '0) err++;
    end
    check("b2b_idle_after", err, 0);

    // Asynchronous reset in the middle of a line.
    pattern = 2'd1; en_s = 1'b1; got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      en_s = 1'b0;
      if (hr_s && px_s == 8'd5) begin
        got = 1;
        break;
      end
    end
    check("href_reached", got, 1);
    res = 1'b1;
    #1;
    check("async_reset_outputs", {vs_s, hr_s, d_s, px_s, py_s, fd_s}, 32'h0);
    @(negedge clk);
    res = 1'b0;
    err = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({vs_s, hr_s, d_s, px_s, py_s, fd_s} != '0) err++;
    end
    check("post_reset_idle", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
